// File: rtl/rv_operand_stage.sv
// Operand-fetch stage: register file, write-back scoreboard with RAW/WAW stall,
// optional write-back bypass and one registered output slot with valid/ready handshake.
module rv_operand_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter bit          BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1_addr,
    input  logic [ADDR_W-1:0] in_rs2_addr,
    input  logic [ADDR_W-1:0] in_rd_addr,
    input  logic              in_rd_we,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              in_use_imm,
    input  logic              in_use_pc,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_op_a,
    output logic [XLEN-1:0]   out_op_b,
    output logic [XLEN-1:0]   out_rs2_data,
    output logic [ADDR_W-1:0] out_rd_addr,
    output logic              out_rd_we,

    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]   wb_data
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    logic            rs1_bypass;
    logic            rs2_bypass;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            hazard;
    logic            fire_in;
    logic            fire_out;

    // Bypass forwards the value being written this edge so the reader need not wait a cycle.
    always_comb begin
        rs1_bypass = BYPASS && wb_en && (wb_addr == in_rs1_addr) && (in_rs1_addr != '0);
        rs2_bypass = BYPASS && wb_en && (wb_addr == in_rs2_addr) && (in_rs2_addr != '0);

        rs1_val = '0;
        if (rs1_bypass) begin
            rs1_val = wb_data;
        end else if (in_rs1_addr != '0) begin
            rs1_val = regs_q[in_rs1_addr];
        end

        rs2_val = '0;
        if (rs2_bypass) begin
            rs2_val = wb_data;
        end else if (in_rs2_addr != '0) begin
            rs2_val = regs_q[in_rs2_addr];
        end
    end

    // rs2 is checked even for immediate forms since it still feeds out_rs2_data.
    always_comb begin
        hazard = (busy_q[in_rs1_addr] && !rs1_bypass)
              || (busy_q[in_rs2_addr] && !rs2_bypass)
              || (in_rd_we && busy_q[in_rd_addr]);
        in_ready = rst && !hazard && (!out_valid || out_ready);
        fire_in  = in_valid && in_ready;
        fire_out = out_valid && out_ready;
    end

    // Clear before set so an issue and a write-back to the same register leave it busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (fire_in && in_rd_we && (in_rd_addr != '0)) begin
            busy_d[in_rd_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_op_a     <= '0;
            out_op_b     <= '0;
            out_rs2_data <= '0;
            out_rd_addr  <= '0;
            out_rd_we    <= 1'b0;
        end else if (fire_in) begin
            out_valid    <= 1'b1;
            out_op_a     <= in_use_pc  ? in_pc  : rs1_val;
            out_op_b     <= in_use_imm ? in_imm : rs2_val;
            out_rs2_data <= rs2_val;
            out_rd_addr  <= in_rd_addr;
            out_rd_we    <= in_rd_we;
        end else if (fire_out) begin
            out_valid    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_operand_stage.sv
// Bench for rv_operand_stage: directed vectors, a per-cycle reference model of the stage
// and a consumer log used to check ordering under backpressure.
module tb_rv_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1_addr;
    logic [4:0]  in_rs2_addr;
    logic [4:0]  in_rd_addr;
    logic        in_rd_we;
    logic [31:0] in_imm;
    logic [31:0] in_pc;
    logic        in_use_imm;
    logic        in_use_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op_a;
    logic [31:0] out_op_b;
    logic [31:0] out_rs2_data;
    logic [4:0]  out_rd_addr;
    logic        out_rd_we;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // Second instance without bypass; shares stimulus, nb_hold extends its in_valid.
    logic        nb_hold;
    logic        nb_in_valid;
    logic        nb_in_ready;
    logic        nb_out_valid;
    logic [31:0] nb_out_op_a;
    logic [31:0] nb_out_op_b;
    logic [31:0] nb_out_rs2_data;
    logic [4:0]  nb_out_rd_addr;
    logic        nb_out_rd_we;

    assign nb_in_valid = in_valid | nb_hold;

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    always #5 clk = ~clk;

    rv_operand_stage #(
        .XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rd_we(in_rd_we), .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op_a(out_op_a), .out_op_b(out_op_b), .out_rs2_data(out_rs2_data),
        .out_rd_addr(out_rd_addr), .out_rd_we(out_rd_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    rv_operand_stage #(
        .XLEN(32), .NREGS(32), .ADDR_W(5), .BYPASS(1'b0)
    ) u_dut_nb (
        .clk(clk), .rst(rst),
        .in_valid(nb_in_valid), .in_ready(nb_in_ready),
        .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
        .in_rd_we(in_rd_we), .in_imm(in_imm), .in_pc(in_pc),
        .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
        .out_valid(nb_out_valid), .out_ready(out_ready),
        .out_op_a(nb_out_op_a), .out_op_b(nb_out_op_b), .out_rs2_data(nb_out_rs2_data),
        .out_rd_addr(nb_out_rd_addr), .out_rd_we(nb_out_rd_we),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model of the bypassing instance: architectural state plus the output slot.
    logic [31:0] m_regs [32] = '{default: 32'h0};
    bit          m_busy [32] = '{default: 1'b0};
    bit          m_ov  = 1'b0;
    logic [31:0] m_a   = '0;
    logic [31:0] m_b   = '0;
    logic [31:0] m_rs2 = '0;
    logic [4:0]  m_rd  = '0;
    bit          m_we  = 1'b0;

    bit          b1, b2, hz, rdy, fi, fo;
    logic [31:0] v1, v2;

    always @(negedge clk) begin
        if (run) begin
            b1  = wb_en && in_rs1_addr != 5'd0 && wb_addr == in_rs1_addr;
            b2  = wb_en && in_rs2_addr != 5'd0 && wb_addr == in_rs2_addr;
            v1  = b1 ? wb_data : m_regs[in_rs1_addr];
            v2  = b2 ? wb_data : m_regs[in_rs2_addr];
            hz  = (m_busy[in_rs1_addr] && !b1) || (m_busy[in_rs2_addr] && !b2)
               || (in_rd_we && m_busy[in_rd_addr]);
            rdy = rst && !hz && (!m_ov || out_ready);

            chk("model in_ready", 32'(in_ready), 32'(rdy));
            chk("model out_valid", 32'(out_valid), 32'(m_ov));
            chk("model out_op_a", out_op_a, m_a);
            chk("model out_op_b", out_op_b, m_b);
            chk("model out_rs2_data", out_rs2_data, m_rs2);
            chk("model out_rd_addr", 32'(out_rd_addr), 32'(m_rd));
            chk("model out_rd_we", 32'(out_rd_we), 32'(m_we));

            fi = in_valid && rdy;
            fo = m_ov && out_ready;
            if (!rst) begin
                m_regs = '{default: 32'h0};
                m_busy = '{default: 1'b0};
                m_ov = 0; m_a = '0; m_b = '0; m_rs2 = '0; m_rd = '0; m_we = 0;
            end else begin
                if (fi) begin
                    m_ov  = 1;
                    m_a   = in_use_pc ? in_pc : v1;
                    m_b   = in_use_imm ? in_imm : v2;
                    m_rs2 = v2;
                    m_rd  = in_rd_addr;
                    m_we  = in_rd_we;
                end else if (fo) begin
                    m_ov = 0;
                end
                if (wb_en) begin
                    if (wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
                    m_busy[wb_addr] = 0;
                end
                if (fi && in_rd_we && in_rd_addr != 5'd0) m_busy[in_rd_addr] = 1;
            end
        end
    end

    logic [31:0] got [$];
    always @(negedge clk) begin
        if (run && out_valid && out_ready) got.push_back(out_op_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 0; in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0; in_rd_we = 0;
        in_imm = '0; in_pc = 32'h8000_0040; in_use_imm = 0; in_use_pc = 0;
        wb_en = 0; wb_addr = '0; wb_data = '0; nb_hold = 0;
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic we, input logic [31:0] imm, input logic use_imm,
                          input logic use_pc);
        in_valid = 1; in_rs1_addr = rs1; in_rs2_addr = rs2; in_rd_addr = rd; in_rd_we = we;
        in_imm = imm; in_use_imm = use_imm; in_use_pc = use_pc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        out_ready = 1;
        // T1: reset held with traffic and write-back present
        rst = 0; in_valid = 1; wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_FFFF;
        tick();
        run = 1;
        neg(); chk("t1 in_ready in reset", 32'(in_ready), 0);
        chk("t1 out_valid in reset", 32'(out_valid), 0);
        tick();
        neg(); chk("t1 in_ready in reset 2", 32'(in_ready), 0);
        tick();
        rst = 1; idle();
        set_in(5, 5, 0, 0, 0, 0, 0);
        neg(); chk("t1 no busy after reset", 32'(in_ready), 1);
        tick(); idle();
        neg(); chk("t1 x5 wb ignored", out_op_a, 0); chk("t1 rs2 zero", out_rs2_data, 0);
        tick();

        // T2: basic read with immediate, then pc/rs2 select
        wb_en = 1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
        tick(); idle();
        set_in(5, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
        neg(); chk("t2 in_ready", 32'(in_ready), 1);
        tick(); set_in(5, 5, 0, 0, 0, 0, 1);
        neg(); chk("t2 op_a", out_op_a, 32'h0000_1234); chk("t2 op_b", out_op_b, 32'hFFFF_FFFC);
        chk("t2 rs2_data", out_rs2_data, 0);
        tick(); idle();
        neg(); chk("t2 pc op_a", out_op_a, 32'h8000_0040); chk("t2 rs2 op_b", out_op_b, 32'h1234);
        tick();

        // T3: RAW on x7, resolved by bypass (and one cycle later without)
        set_in(0, 0, 7, 1, 0, 0, 0);
        tick(); idle(); set_in(7, 0, 0, 0, 0, 0, 0);
        neg(); chk("t3 raw stall", 32'(in_ready), 0);
        tick();
        neg(); chk("t3 raw stall 2", 32'(in_ready), 0); chk("t3 nb stall", 32'(nb_in_ready), 0);
        tick(); wb_en = 1; wb_addr = 5'd7; wb_data = 32'hA5A5_0001;
        neg(); chk("t3 bypass accept", 32'(in_ready), 1);
        chk("t3 nb stall in wb cycle", 32'(nb_in_ready), 0);
        tick(); in_valid = 0; wb_en = 0; nb_hold = 1;
        neg(); chk("t3 bypass op_a", out_op_a, 32'hA5A5_0001);
        chk("t3 nb accept after wb", 32'(nb_in_ready), 1);
        tick(); idle();
        neg(); chk("t3 nb op_a", nb_out_op_a, 32'hA5A5_0001);
        chk("t3 nb out_valid", 32'(nb_out_valid), 1);
        tick();

        // T4: backpressure then a streamed run of 8
        got.delete();
        set_in(0, 0, 0, 0, 32'h100, 1, 0); out_ready = 0;
        neg(); chk("t4 first accept", 32'(in_ready), 1);
        tick(); set_in(0, 0, 0, 0, 32'h200, 1, 0);
        for (int i = 0; i < 3; i++) begin
            neg(); chk("t4 held in_ready", 32'(in_ready), 0);
            chk("t4 held op_b", out_op_b, 32'h100); chk("t4 held valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1;
        for (int i = 0; i < 8; i++) begin
            in_imm = 32'h200 + 32'(i);
            neg(); chk("t4 stream in_ready", 32'(in_ready), 1);
            tick();
        end
        idle(); tick(); tick();
        chk("t4 transfer count", 32'(got.size()), 9);
        if (got.size() == 9) begin
            chk("t4 order head", got[0], 32'h100);
            for (int i = 1; i < 9; i++) chk("t4 order", got[i], 32'h1FF + 32'(i));
        end

        // T5: x0 semantics, WAW on x3, set-wins on x4
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
        tick(); idle(); set_in(0, 0, 0, 1, 0, 0, 0);
        neg(); chk("t5 rd0 accept", 32'(in_ready), 1);
        tick();
        neg(); chk("t5 rd0 no waw", 32'(in_ready), 1);
        tick(); idle();
        neg(); chk("t5 x0 op_a", out_op_a, 0); chk("t5 x0 op_b", out_op_b, 0);
        set_in(0, 0, 3, 1, 0, 0, 0);
        tick();
        neg(); chk("t5 waw stall", 32'(in_ready), 0);
        tick(); wb_en = 1; wb_addr = 5'd3; wb_data = 32'h33;
        tick(); wb_en = 0;
        neg(); chk("t5 waw released", 32'(in_ready), 1);
        tick(); idle();
        set_in(0, 0, 4, 1, 0, 0, 0); wb_en = 1; wb_addr = 5'd4; wb_data = 32'h44;
        tick(); idle(); set_in(4, 0, 0, 0, 0, 0, 0);
        neg(); chk("t5 set wins", 32'(in_ready), 0);
        tick(); wb_en = 1; wb_addr = 5'd4; wb_data = 32'h55;
        neg(); chk("t5 x4 bypass accept", 32'(in_ready), 1);
        tick(); idle();
        neg(); chk("t5 x4 op_a", out_op_a, 32'h55);
        tick();

        // T6: reset with a bundle in flight and x9 busy
        set_in(0, 0, 9, 1, 0, 0, 0); out_ready = 0;
        tick(); idle(); rst = 0;
        neg(); chk("t6 valid before reset", 32'(out_valid), 1);
        tick(); rst = 1;
        neg(); chk("t6 valid cleared", 32'(out_valid), 0);
        tick(); set_in(9, 7, 0, 0, 0, 0, 0);
        neg(); chk("t6 busy cleared", 32'(in_ready), 1);
        tick(); idle(); out_ready = 1;
        neg(); chk("t6 x7 cleared", out_rs2_data, 0); chk("t6 op_a", out_op_a, 0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
